// File: rtl/toggle_pulse_sender_if.sv
// ============================================================================
// toggle_pulse_sender_if : event/handshake bundle of the toggle pulse sender
// Rev 1.0
// ============================================================================
`default_nettype none

interface toggle_pulse_sender_if #(
   parameter int CNT_W = 4
);
   logic             i_pulse;
   logic             i_ack_tgl;
   logic             i_clr_ovf;
   logic             o_req_tgl;
   logic             o_busy;
   logic [CNT_W-1:0] o_pending;
   logic             o_overflow;

   modport master (
      output i_pulse, i_ack_tgl, i_clr_ovf,
      input  o_req_tgl, o_busy, o_pending, o_overflow
   );

   modport slave (
      input  i_pulse, i_ack_tgl, i_clr_ovf,
      output o_req_tgl, o_busy, o_pending, o_overflow
   );
endinterface

`default_nettype wire

// File: rtl/toggle_pulse_sender.sv
// ============================================================================
// toggle_pulse_sender : pulse-to-toggle source of a two-phase event crossing
// Rev 1.0
// ============================================================================
`default_nettype none

module toggle_pulse_sender #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4
) (
   input  wire logic               i_clk,
   input  wire logic               i_rst_n,
   toggle_pulse_sender_if.slave    bus
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [SYNC_STAGES-1:0] r_ack_s;
   logic                   r_req_tgl;
   logic [CNT_W-1:0]       r_pending;
   logic [CNT_W-1:0]       w_pending_nxt;
   logic                   r_overflow;
   logic                   w_launch;
   logic                   w_drop;
   logic                   w_handshake;

   assign w_handshake = (r_ack_s[SYNC_STAGES-1] == r_req_tgl);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_ack_s    <= '0;
         r_req_tgl  <= 1'b0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ack_s    <= {r_ack_s[SYNC_STAGES-2:0], bus.i_ack_tgl};
         r_req_tgl  <= r_req_tgl ^ w_launch;
         r_pending  <= w_pending_nxt;
         if (w_drop)
            r_overflow <= 1'b1;
         else if (bus.i_clr_ovf)
            r_overflow <= 1'b0;
      end
   end

   // Launch decisions look only at the registered count, so a same-cycle pulse waits one edge
   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_pending != '0) begin
               w_launch    = 1'b1;
               w_state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (w_handshake) begin
               if (r_pending != '0)
                  w_launch = 1'b1;
               else
                  w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_pending_nxt = r_pending;
      w_drop        = 1'b0;
      case ({bus.i_pulse, w_launch})
         2'b10: begin
            if (r_pending == C_CNT_MAX)
               w_drop = 1'b1;
            else
               w_pending_nxt = r_pending + C_CNT_ONE;
         end
         2'b01:   w_pending_nxt = r_pending - C_CNT_ONE;
         default: w_pending_nxt = r_pending;
      endcase
   end

   assign bus.o_req_tgl  = r_req_tgl;
   assign bus.o_busy     = (r_state == WAIT_ACK);
   assign bus.o_pending  = r_pending;
   assign bus.o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_toggle_pulse_sender.sv
// Scoreboard bench for toggle_pulse_sender: driver feeds a cycle-level event model,
// monitor compares DUT status and request toggles against the queued expectations.
module tb_toggle_pulse_sender;

   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 3;
   localparam int MAXC        = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   toggle_pulse_sender_if #(.CNT_W(CNT_W)) bus ();

   toggle_pulse_sender #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   typedef struct {
      int cyc;
      bit req;
      bit busy;
      int pending;
      bit ovf;
   } exp_t;

   exp_t st_q[$];
   int   launch_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_tgl = 0;
   int   n_busy = 0;
   int   peak = 0;

   // reference model: event-level view of the sender plus the far-end loopback
   int   m_pending;
   bit   m_busy, m_req, m_ovf;
   bit   m_pipe[SYNC_STAGES];
   bit   hist[8];
   int   ack_mode;
   int   ack_dly;
   bit   ack_drv;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pending = 0;
      m_busy    = 0;
      m_req     = 0;
      m_ovf     = 0;
      for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 0;
      for (int i = 0; i < 8; i++) hist[i] = 0;
      ack_drv = 0;
      st_q.delete();
      launch_q.delete();
   endtask

   task automatic step(input bit pulse, input bit clr);
      bit hs, launch;
      int np;
      @(posedge clk);
      #1;
      if (ack_mode == 0) ack_drv = hist[ack_dly-1];
      bus.i_pulse   = pulse;
      bus.i_clr_ovf = clr;
      bus.i_ack_tgl = ack_drv;
      hs     = (m_pipe[SYNC_STAGES-1] == m_req);
      launch = (m_pending > 0) && (!m_busy || hs);
      m_busy = launch || (m_busy && !hs);
      np = m_pending + int'(pulse) - int'(launch);
      if (np > MAXC) begin
         np    = MAXC;
         m_ovf = 1;
      end else if (clr) begin
         m_ovf = 0;
      end
      m_pending = np;
      if (launch) begin
         m_req = !m_req;
         launch_q.push_back(cyc + 1);
      end
      for (int i = SYNC_STAGES-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = ack_drv;
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_req;
      st_q.push_back('{cyc + 1, m_req, m_busy, m_pending, m_ovf});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0);
   endtask

   // monitor: samples 2 time units after each rising edge
   initial begin
      exp_t e;
      bit   prev_req;
      prev_req = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            prev_req = 0;
            continue;
         end
         while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
            e = st_q.pop_front();
            chk("status_missing", cyc, e.cyc);
         end
         if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
            e = st_q.pop_front();
            chk("req_tgl", int'(bus.o_req_tgl), int'(e.req));
            chk("busy",    int'(bus.o_busy),    int'(e.busy));
            chk("pending", int'(bus.o_pending), e.pending);
            chk("overflow", int'(bus.o_overflow), int'(e.ovf));
         end
         if (bus.o_busy) n_busy++;
         if (int'(bus.o_pending) > peak) peak = int'(bus.o_pending);
         if (bus.o_req_tgl !== prev_req) begin
            n_tgl++;
            if (launch_q.size() == 0)
               chk("spurious_toggle", 1, 0);
            else
               chk("launch_cycle", cyc, launch_q.pop_front());
            prev_req = bus.o_req_tgl;
         end
      end
   end

   initial begin
      int t0;
      bus.i_pulse   = 0;
      bus.i_clr_ovf = 0;
      bus.i_ack_tgl = 0;
      ack_mode = 0;
      ack_dly  = 4;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req",  int'(bus.o_req_tgl), 0);
      chk("rst_busy", int'(bus.o_busy), 0);
      chk("rst_pend", int'(bus.o_pending), 0);
      chk("rst_ovf",  int'(bus.o_overflow), 0);
      rst_n = 1;

      // single pulse with loopback
      idle(2);
      t0 = n_tgl; n_busy = 0;
      step(1, 0);
      idle(20);
      chk("single_toggles", n_tgl - t0, 1);
      chk("single_busy_cycles", n_busy, 6);

      // burst of five
      t0 = n_tgl; peak = 0;
      for (int i = 0; i < 5; i++) step(1, 0);
      idle(40);
      chk("burst_toggles", n_tgl - t0, 5);
      chk("burst_peak", peak, 4);
      chk("burst_ovf", int'(bus.o_overflow), 0);

      // saturation with ack stuck, then release and clear
      ack_mode = 1;
      t0 = n_tgl;
      for (int i = 0; i < MAXC + 2; i++) step(1, 0);
      step(1, 1);
      idle(25);
      #2;
      chk("stuck_toggles", n_tgl - t0, 1);
      chk("stuck_busy", int'(bus.o_busy), 1);
      chk("sat_pending", int'(bus.o_pending), MAXC);
      chk("sat_ovf_kept", int'(bus.o_overflow), 1);
      ack_mode = 0;
      idle(80);
      chk("release_toggles", n_tgl - t0, 1 + MAXC);
      chk("ovf_sticky", int'(bus.o_overflow), 1);
      step(0, 1);
      idle(2);

      // asynchronous reset while in flight
      ack_mode = 1;
      for (int i = 0; i < 4; i++) step(1, 0);
      step(0, 0);
      #2;
      chk("pre_rst_pend", int'(bus.o_pending), 3);
      chk("pre_rst_busy", int'(bus.o_busy), 1);
      rst_n = 0;
      #1;
      chk("arst_req",  int'(bus.o_req_tgl), 0);
      chk("arst_busy", int'(bus.o_busy), 0);
      chk("arst_pend", int'(bus.o_pending), 0);
      chk("arst_ovf",  int'(bus.o_overflow), 0);
      bus.i_pulse = 0;
      bus.i_clr_ovf = 0;
      bus.i_ack_tgl = 0;
      ack_mode = 0;
      ack_dly  = 4;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      t0 = n_tgl;
      step(1, 0);
      idle(3);
      #2;
      chk("post_rst_toggle", n_tgl - t0, 1);
      chk("post_rst_req", int'(bus.o_req_tgl), 1);
      idle(20);

      // randomized traffic
      for (int blk = 0; blk < 8; blk++) begin
         ack_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
         ack_dly  = $urandom_range(1, 6);
         for (int i = 0; i < 50; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      end

      // drain
      ack_mode = 0;
      ack_dly  = 4;
      idle(80);
      @(posedge clk);
      #3;
      chk("status_q_empty", st_q.size(), 0);
      chk("launch_q_empty", launch_q.size(), 0);
      chk("final_pending", int'(bus.o_pending), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/toggle_pulse_sender.md
# toggle_pulse_sender

Source end of the two-phase toggle crossing: converts single-cycle event pulses in the `i_clk` domain into a request toggle for a far-domain toggle-to-pulse synchronizer. It waits for that synchronizer's acknowledge toggle before launching the next event. A saturating pending-event counter absorbs bursts so no event is lost until the counter is full. The block sits on the sending side of every toggle-synchronized event path; the far end resynchronizes `o_req_tgl` and XORs adjacent stages back into a pulse.

## Interface
- `SYNC_STAGES`, default 2: flops in the `i_ack_tgl` synchronizer; legal range ≥2.
- `CNT_W`, default 4: pending-counter width; maximum count is 2^CNT_W−1.
- `i_clk`, input, 1: clock; all logic is on the rising edge.
- `i_rst_n`, input, 1: reset, asynchronous, active-low; the block has one clock, `i_clk`.
- `i_pulse`, input, 1: event request; each cycle it is high counts as one event.
- `i_ack_tgl`, input, 1: acknowledge toggle from the far domain; asynchronous to `i_clk`.
- `i_clr_ovf`, input, 1: synchronous clear of `o_overflow`.
- `o_req_tgl`, output, 1: request toggle; it flips once per launched event and is driven directly from a flop.
- `o_busy`, output, 1: high while an event is in flight (state WAIT_ACK).
- `o_pending`, output, CNT_W: number of events accepted but not yet launched.
- `o_overflow`, output, 1: sticky flag; set when an event is dropped.

## Operation
- Reset values: `o_req_tgl`=0, `o_busy`=0, `o_pending`=0, `o_overflow`=0, all ack synchronizer flops=0, state=IDLE.
- Ack synchronizer:
  - `ack_s` is a shift chain of SYNC_STAGES flops clocked by `i_clk`.
  - `ack_sync` is the last stage of that chain.
  - No other logic samples `i_ack_tgl`.
- The block is in handshake when `ack_sync == o_req_tgl`.
- State machine, two states:
  - **IDLE**, `o_busy`=0. If `o_pending`≠0: flip `o_req_tgl`, decrement the pending count, go to WAIT_ACK. Otherwise stay in IDLE.
  - **WAIT_ACK**, `o_busy`=1. If in handshake and `o_pending`≠0: flip `o_req_tgl`, decrement, stay in WAIT_ACK (back-to-back launch). If in handshake and `o_pending`=0: go to IDLE. If not in handshake: hold.
- Launch decisions use the registered `o_pending` value. A pulse arriving in the same cycle cannot launch in that cycle.
- Pending counter, updated each cycle. Let inc=`i_pulse` and dec=the launch taken this cycle.
  - inc without dec: +1. At 2^CNT_W−1 it holds instead, and `o_overflow` is set.
  - dec without inc: −1.
  - inc and dec together: the count is unchanged. No overflow is possible in this case.
  - Neither: hold.
- `o_overflow`:
  - Set has priority over `i_clr_ovf` in the same cycle.
  - `i_clr_ovf` without a concurrent drop clears the flag at the next edge.
- Reset mid-operation clears everything immediately, including an in-flight event and pending events. The far end must be reset in the same reset domain so that req and ack both restart at 0. A reset on this side only is unsupported.

## Timing
- Pulse to request: `i_pulse` sampled high at edge E0 while the block is IDLE with `o_pending`=0.
  - After E0: `o_pending`=1.
  - After E1: `o_req_tgl` flips, `o_pending`=0, `o_busy`=1.
  - Latency is 2 edges.
- Acknowledge: `i_ack_tgl` changes and is stable before edge A1.
  - `ack_sync` matches after edge A(SYNC_STAGES).
  - The FSM acts at edge A(SYNC_STAGES+1): it either relaunches or returns to IDLE.
- Minimum launch spacing:
  - Back-to-back launches are SYNC_STAGES+1 edges after ack arrival, plus the far-end turnaround.
  - The `o_busy` high-to-low transition occurs at the same edge as the final handshake.
- `o_pending` and `o_overflow` are registered and update at the edge after the event that changes them.
- `i_pulse` has no handshake; it is accepted every cycle subject to saturation.

## Test plan
- Reset then single pulse, loopback `i_ack_tgl` = `o_req_tgl` delayed by 3 cycles, SYNC_STAGES=2 -> `o_req_tgl` 0→1 two edges after the pulse; `o_busy` high for 6 cycles; `o_pending` returns to 0; exactly one toggle.
- Burst of 5 consecutive pulses, same loopback -> `o_pending` peaks at 4; 5 toggles total; each relaunch occurs 3 edges after the ack change; `o_overflow`=0.
- CNT_W=2, 5 pulses while ack held (no loopback) -> 1 launched, `o_pending` saturates at 3, `o_overflow`=1 after the 5th pulse. Then release ack -> 3 further toggles; overflow stays 1 until `i_clr_ovf`.
- `i_pulse` and a launch in the same cycle with `o_pending`=2 -> `o_pending` stays 2. `i_clr_ovf` and a drop in the same cycle -> `o_overflow` remains 1.
- Assert `i_rst_n` low in WAIT_ACK with `o_pending`=3 -> all outputs 0 immediately and asynchronously, with no clock edge needed. After release, the first pulse produces a 0→1 toggle.
- Glitch check: ack toggles never seen (ack stuck) -> `o_req_tgl` is stable and `o_busy` stays 1 indefinitely; no spurious toggle.
